shreg_universal: RTL and testbench

- Parametrised universal shift register; successor to the fixed 4-bit parallel-load/shift-right register.
- Adds configurable width and clock enable, plus left shift, both rotates and synchronous clear.
- Adds a self-timed serializer (PISO burst) with busy/valid/done status.
- Used as the general-purpose serial/parallel conversion element across the design.

---
 rtl/shreg_universal.sv | 100 ++++++++++
 tb/tb_shreg_universal.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/shreg_universal.sv
// Universal shift register: parallel load, shift/rotate both ways,
// synchronous clear, and a self-timed LSB-first serializer (PISO burst).
module shreg_universal #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [2:0]                 mode,
  input  logic [WIDTH-1:0]           pin,
  input  logic                       sin_r,
  input  logic                       sin_l,
  input  logic                       start,
  output logic [WIDTH-1:0]           q,
  output logic                       sout_r,
  output logic                       sout_l,
  output logic                       ser_valid,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH+1)-1:0] cnt
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]  cnt_nxt;

  // State, data and burst counter advance together, only on enabled edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      q     <= RST_VAL;
      cnt   <= '0;
    end else if (en) begin
      state <= state_nxt;
      q     <= q_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state decode: start beats mode in IDLE; a burst ignores all requests.
  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          q_nxt     = pin;
          cnt_nxt   = CW'(WIDTH);
          state_nxt = SHIFT;
        end else begin
          case (mode)
            3'b001:  q_nxt = pin;
            3'b010:  q_nxt = {sin_r, q[WIDTH-1:1]};
            3'b011:  q_nxt = {q[WIDTH-2:0], sin_l};
            3'b100:  q_nxt = {q[0], q[WIDTH-1:1]};
            3'b101:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            3'b111:  q_nxt = '0;
            default: q_nxt = q;
          endcase
        end
      end
      SHIFT: begin
        q_nxt = {sin_r, q[WIDTH-1:1]};
        if (cnt == CW'(1)) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Status and serial outputs come from registered state only.
  always_comb begin
    sout_r    = q[0];
    sout_l    = q[WIDTH-1];
    busy      = (state == SHIFT);
    ser_valid = (state == SHIFT);
    done      = (state == DONE);
  end

endmodule

// File: tb/tb_shreg_universal.sv
// Scoreboard bench for shreg_universal (WIDTH=4): stimulus pushes expected
// responses from a behavioural model; a monitor pops and compares each cycle.
module tb_shreg_universal;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] pin;
  logic         sin_r;
  logic         sin_l;
  logic         start;
  logic [W-1:0] q;
  logic         sout_r;
  logic         sout_l;
  logic         ser_valid;
  logic         busy;
  logic         done;
  logic [2:0]   cnt;

  typedef struct {
    int q;
    int busy;
    int done;
    int cnt;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  // Behavioural model: register value, bits still to send, done-cycle flag.
  int mq    = 0;
  int mleft = 0;
  bit mdone = 0;

  shreg_universal #(.WIDTH(W), .RST_VAL('0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .pin(pin),
    .sin_r(sin_r), .sin_l(sin_l), .start(start), .q(q),
    .sout_r(sout_r), .sout_l(sout_l), .ser_valid(ser_valid),
    .busy(busy), .done(done), .cnt(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkField(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("[TB] FAIL %s (cycle %0d): got %0d, expected %0d", name, cycle, act, expv);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("q",         int'(q),         e.q);
    checkField("sout_r",    int'(sout_r),    e.q & 1);
    checkField("sout_l",    int'(sout_l),    (e.q >> (W - 1)) & 1);
    checkField("busy",      int'(busy),      e.busy);
    checkField("ser_valid", int'(ser_valid), e.busy);
    checkField("done",      int'(done),      e.done);
    checkField("cnt",       int'(cnt),       e.cnt);
  endtask

  function automatic exp_t modelExp();
    exp_t e;
    e.q    = mq;
    e.busy = (mleft > 0) ? 1 : 0;
    e.done = mdone ? 1 : 0;
    e.cnt  = mleft;
    return e;
  endfunction

  // One enabled rising edge of the reference behaviour.
  task automatic modelStep(input logic s, input logic [2:0] m, input logic [W-1:0] p,
                           input logic sr, input logic sl);
    if (mleft > 0) begin
      mq = (mq >> 1) | (int'(sr) << (W - 1));
      mleft = mleft - 1;
      if (mleft == 0) mdone = 1;
    end else if (mdone) begin
      mdone = 0;
    end else if (s) begin
      mq    = int'(p);
      mleft = W;
    end else begin
      case (m)
        3'd1: mq = int'(p);
        3'd2: mq = (mq >> 1) | (int'(sr) << (W - 1));
        3'd3: mq = ((mq << 1) & MASK) | int'(sl);
        3'd4: mq = (mq >> 1) | ((mq & 1) << (W - 1));
        3'd5: mq = ((mq << 1) & MASK) | ((mq >> (W - 1)) & 1);
        3'd7: mq = 0;
        default: ;
      endcase
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expected result.
  task automatic applyStimulus(input logic r, input logic e, input logic s,
                               input logic [2:0] m, input logic [W-1:0] p,
                               input logic sr, input logic sl);
    @(negedge clk);
    rst_n = r; en = e; start = s; mode = m; pin = p; sin_r = sr; sin_l = sl;
    if (!r) begin
      mq = 0; mleft = 0; mdone = 0;
    end else if (e) begin
      modelStep(s, m, p, sr, sl);
    end
    exp_q.push_back(modelExp());
  endtask

  task automatic idleCycle(input logic s, input logic [2:0] m, input logic [W-1:0] p,
                           input logic sr);
    applyStimulus(1'b1, 1'b1, s, m, p, sr, 1'b0);
  endtask

  // Monitor: after each rising edge, compare the DUT against the oldest expectation.
  always @(posedge clk) begin
    #1;
    cycle++;
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  initial begin
    exp_t rst_exp;
    rst_n = 1'b0; en = 1'b0; start = 1'b0; mode = 3'd0; pin = '0;
    sin_r = 1'b0; sin_l = 1'b0;

    // Reset state
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd1, 4'hF, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd1, 4'hF, 1'b1, 1'b1);

    // Load then shift right
    idleCycle(1'b0, 3'd1, 4'b1011, 1'b0);
    idleCycle(1'b0, 3'd2, 4'b0000, 1'b1);
    idleCycle(1'b0, 3'd2, 4'b0000, 1'b0);

    // Shift left, rotates, reserved, clear
    idleCycle(1'b0, 3'd1, 4'b1011, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd3, 4'b0000, 1'b0, 1'b0);
    idleCycle(1'b0, 3'd1, 4'b1011, 1'b0);
    idleCycle(1'b0, 3'd4, 4'b0000, 1'b0);
    idleCycle(1'b0, 3'd1, 4'b1011, 1'b0);
    idleCycle(1'b0, 3'd5, 4'b0000, 1'b0);
    idleCycle(1'b0, 3'd6, 4'b1111, 1'b1);
    idleCycle(1'b0, 3'd0, 4'b1111, 1'b1);
    idleCycle(1'b0, 3'd7, 4'b0000, 1'b0);

    // Serialize 1010 with sin_r=0
    idleCycle(1'b1, 3'd0, 4'b1010, 1'b0);
    repeat (4) idleCycle(1'b0, 3'd0, 4'b0000, 1'b0);
    idleCycle(1'b0, 3'd0, 4'b0000, 1'b0);
    idleCycle(1'b0, 3'd0, 4'b0000, 1'b0);

    // Ignored requests during burst and in the done cycle
    idleCycle(1'b1, 3'd0, 4'b1100, 1'b1);
    repeat (4) idleCycle(1'b1, 3'd1, 4'b1111, 1'b0);
    idleCycle(1'b1, 3'd1, 4'b0110, 1'b0);
    idleCycle(1'b0, 3'd0, 4'b0000, 1'b0);

    // Enable stall mid-burst
    idleCycle(1'b1, 3'd0, 4'b1001, 1'b1);
    repeat (2) idleCycle(1'b0, 3'd0, 4'b0000, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 3'd1, 4'b1111, 1'b0, 1'b1);
    repeat (2) idleCycle(1'b0, 3'd0, 4'b0000, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0);
    idleCycle(1'b0, 3'd0, 4'b0000, 1'b0);

    // Asynchronous reset between edges during a burst
    idleCycle(1'b1, 3'd0, 4'b1111, 1'b1);
    repeat (2) idleCycle(1'b0, 3'd0, 4'b0000, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    mq = 0; mleft = 0; mdone = 0;
    #1;
    rst_exp = modelExp();
    checkOutput(rst_exp);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0);
    idleCycle(1'b0, 3'd0, 4'b0000, 1'b0);
    idleCycle(1'b0, 3'd1, 4'b0101, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'b1, ($urandom_range(9) != 0), ($urandom_range(5) == 0),
                    3'($urandom_range(7)), 4'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
